// File: rtl/mem_stage_pkg.sv
// Opcode constants and decode helper for the data-memory stage.
// Latency: none (constants and a pure function only).
// Backpressure: not applicable.
package mem_stage_pkg;

    // MIPS load/store opcodes (Ins[31:26])
    localparam logic [5:0] LB  = 6'h20;
    localparam logic [5:0] LH  = 6'h21;
    localparam logic [5:0] LW  = 6'h23;
    localparam logic [5:0] LBU = 6'h24;
    localparam logic [5:0] LHU = 6'h25;
    localparam logic [5:0] SB  = 6'h28;
    localparam logic [5:0] SH  = 6'h29;
    localparam logic [5:0] SW  = 6'h2B;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } acc_size_t;

    typedef struct packed {
        logic      is_load;
        logic      is_store;
        acc_size_t size;
        logic      sign_ext;
    } mem_ctl_t;

    // Non-memory opcodes decode to all-zero control (no read, no write).
    function automatic mem_ctl_t decode_op(input logic [5:0] op);
        mem_ctl_t c;
        c.is_load  = 1'b0;
        c.is_store = 1'b0;
        c.size     = SZ_WORD;
        c.sign_ext = 1'b0;
        case (op)
            LB:  begin c.is_load  = 1'b1; c.size = SZ_BYTE; c.sign_ext = 1'b1; end
            LH:  begin c.is_load  = 1'b1; c.size = SZ_HALF; c.sign_ext = 1'b1; end
            LW:  begin c.is_load  = 1'b1; c.size = SZ_WORD; end
            LBU: begin c.is_load  = 1'b1; c.size = SZ_BYTE; end
            LHU: begin c.is_load  = 1'b1; c.size = SZ_HALF; end
            SB:  begin c.is_store = 1'b1; c.size = SZ_BYTE; end
            SH:  begin c.is_store = 1'b1; c.size = SZ_HALF; end
            SW:  begin c.is_store = 1'b1; c.size = SZ_WORD; end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/dmem_be.sv
// Data memory: DMEM_WORDS x 32 array, byte-enabled synchronous write, async read.
// Latency: read combinational; write commits on the rising CLK edge.
// Backpressure: none, accepts one access every cycle.
// Ports: CLK, we (write strobe), be[3:0] (be[3] = bits 31:24), addr (word index),
//        wdata (lane-replicated store data), rdata (addressed word).
module dmem_be #(
    parameter int DMEM_WORDS = 1024,
    parameter int AW         = $clog2(DMEM_WORDS)
) (
    input  logic          CLK,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DMEM_WORDS];

    always_ff @(posedge CLK) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// MIPS data-memory stage: byte/half/word loads and stores with sticky misalignment fault.
// Latency: load data combinational in the same cycle; stores and fault update on next edge.
// Backpressure: none, one instruction per cycle.
// Ports: CLK, RST (sync, active-high), Ins (opcode in [31:26]), Result (effective
//        address), Rdata2 (store data), WBdata (write-back), Ldata (extended load
//        data), Fault (sticky misalignment), BadAddr (first faulting address).
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DMEM_WORDS = 1024,
    parameter int AW         = $clog2(DMEM_WORDS)
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] Ins,
    input  logic [31:0] Result,
    input  logic [31:0] Rdata2,
    output logic [31:0] WBdata,
    output logic [31:0] Ldata,
    output logic        Fault,
    output logic [31:0] BadAddr
);

    mem_ctl_t    ctl;
    logic [1:0]  off;
    logic        misalign;
    logic        mem_op;
    logic        dmem_we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    assign ctl    = decode_op(Ins[31:26]);
    assign off    = Result[1:0];
    assign mem_op = ctl.is_load | ctl.is_store;

    always_comb begin
        misalign = 1'b0;
        case (ctl.size)
            SZ_HALF: misalign = off[0];
            SZ_WORD: misalign = (off != 2'b00);
            default: misalign = 1'b0;
        endcase
    end

    // Lane enables are big-endian: byte offset 0 is be[3] / bits [31:24].
    // Store data is replicated across lanes so the enable alone picks the target.
    always_comb begin
        be    = 4'b1111;
        wdata = Rdata2;
        case (ctl.size)
            SZ_BYTE: begin
                be    = 4'b1000 >> off;
                wdata = {4{Rdata2[7:0]}};
            end
            SZ_HALF: begin
                be    = off[1] ? 4'b0011 : 4'b1100;
                wdata = {2{Rdata2[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = Rdata2;
            end
        endcase
    end

    assign dmem_we = ctl.is_store & ~misalign & ~RST;

    dmem_be #(
        .DMEM_WORDS (DMEM_WORDS),
        .AW         (AW)
    ) u_dmem (
        .CLK   (CLK),
        .we    (dmem_we),
        .be    (be),
        .addr  (Result[AW+1:2]),
        .wdata (wdata),
        .rdata (rdata)
    );

    always_comb begin
        ld_byte = 8'h00;
        case (off)
            2'd0: ld_byte = rdata[31:24];
            2'd1: ld_byte = rdata[23:16];
            2'd2: ld_byte = rdata[15:8];
            default: ld_byte = rdata[7:0];
        endcase
    end

    assign ld_half = off[1] ? rdata[15:0] : rdata[31:16];

    always_comb begin
        ld_ext = rdata;
        case (ctl.size)
            SZ_BYTE: ld_ext = {{24{ctl.sign_ext & ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_ext = {{16{ctl.sign_ext & ld_half[15]}}, ld_half};
            default: ld_ext = rdata;
        endcase
    end

    assign Ldata  = (ctl.is_load & ~misalign) ? ld_ext : 32'h0;
    assign WBdata = ctl.is_load ? Ldata : Result;

    // BadAddr only latches on the first fault; later faults leave it alone.
    always_ff @(posedge CLK) begin
        if (RST) begin
            Fault   <= 1'b0;
            BadAddr <= 32'h0;
        end else if (mem_op & misalign) begin
            Fault <= 1'b1;
            if (!Fault) begin
                BadAddr <= Result;
            end
        end
    end

    // Opcode function fields and upper address bits are not needed here.
    logic unused_bits;
    assign unused_bits = ^{Ins[25:0], Result[31:AW+2]};

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage against a byte-array reference model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int WORDS = 1024;
    localparam int NBYTES = 4 * WORDS;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] Ins;
    logic [31:0] Result;
    logic [31:0] Rdata2;
    logic [31:0] WBdata;
    logic [31:0] Ldata;
    logic        Fault;
    logic [31:0] BadAddr;

    mem_stage #(.DMEM_WORDS(WORDS)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .Ins     (Ins),
        .Result  (Result),
        .Rdata2  (Rdata2),
        .WBdata  (WBdata),
        .Ldata   (Ldata),
        .Fault   (Fault),
        .BadAddr (BadAddr)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [7:0]  m_bytes [NBYTES];
    logic        m_fault;
    logic [31:0] m_bad;

    // last observed combinational outputs
    logic [31:0] obs_ld;
    logic [31:0] obs_wb;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    function automatic int acc_bytes(input logic [5:0] op);
        case (op)
            6'h20, 6'h24, 6'h28: return 1;
            6'h21, 6'h25, 6'h29: return 2;
            6'h23, 6'h2B:        return 4;
            default:             return 0;
        endcase
    endfunction

    function automatic bit op_is_load(input logic [5:0] op);
        return (op == 6'h20) || (op == 6'h21) || (op == 6'h23) || (op == 6'h24) || (op == 6'h25);
    endfunction

    function automatic bit op_is_store(input logic [5:0] op);
        return (op == 6'h28) || (op == 6'h29) || (op == 6'h2B);
    endfunction

    // One instruction per cycle: apply inputs, check combinational outputs,
    // advance the model, clock, then check the sticky fault state.
    task automatic do_op(input logic rst, input logic [5:0] op,
                         input logic [31:0] res, input logic [31:0] d2);
        int          n;
        int          base;
        bit          mis;
        logic [31:0] v;
        logic [31:0] exp_ld;
        logic [31:0] exp_wb;
        RST    = rst;
        Ins    = {op, 26'h0155AA3};
        Result = res;
        Rdata2 = d2;
        n      = acc_bytes(op);
        mis    = (n == 2 && res[0]) || (n == 4 && res[1:0] != 2'b00);
        base   = int'(res % NBYTES);
        v      = 32'h0;
        for (int i = 0; i < n; i++) v = (v << 8) | 32'(m_bytes[base + i]);
        if ((op == 6'h20) && v >= 32'h80)   v = v - 32'h100;
        if ((op == 6'h21) && v >= 32'h8000) v = v - 32'h10000;
        exp_ld = (op_is_load(op) && !mis) ? v : 32'h0;
        exp_wb = op_is_load(op) ? exp_ld : res;
        #3;
        obs_ld = Ldata;
        obs_wb = WBdata;
        check("ldata", Ldata, exp_ld);
        check("wbdata", WBdata, exp_wb);
        if (rst) begin
            m_fault = 1'b0;
            m_bad   = 32'h0;
        end else if (mis) begin
            if (!m_fault) m_bad = res;
            m_fault = 1'b1;
        end else if (op_is_store(op)) begin
            for (int i = 0; i < n; i++) m_bytes[base + i] = 8'(d2 >> (8 * (n - 1 - i)));
        end
        @(posedge CLK);
        #1;
        check("fault", 32'(Fault), 32'(m_fault));
        check("badaddr", BadAddr, m_bad);
    endtask

    logic [5:0] op_tbl [10] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25,
                                 6'h28, 6'h29, 6'h2B, 6'h00, 6'h08};

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        logic [31:0] raw;
        logic [31:0] addr;
        m_fault = 1'b0;
        m_bad   = 32'h0;
        for (int i = 0; i < NBYTES; i++) m_bytes[i] = 8'h00;

        // reset state
        do_op(1'b1, 6'h00, 32'h0, 32'h0);
        check("rst_fault", 32'(Fault), 32'h0);
        check("rst_badaddr", BadAddr, 32'h0);

        // give the DUT memory a known all-zero image
        for (int w = 0; w < WORDS; w++) do_op(1'b0, SW, 32'(w * 4), 32'h0);

        // word round trip
        do_op(1'b0, SW, 32'h10, 32'hDEADBEEF);
        do_op(1'b0, LW, 32'h10, 32'h0);
        check("lw_rt_ld", obs_ld, 32'hDEADBEEF);
        check("lw_rt_wb", obs_wb, 32'hDEADBEEF);

        // byte lanes over a zero word
        do_op(1'b0, SW, 32'h10, 32'h0);
        do_op(1'b0, SB, 32'h11, 32'h000000A5);
        do_op(1'b0, LW, 32'h10, 32'h0);
        check("sb_word", obs_ld, 32'h00A50000);
        do_op(1'b0, LB, 32'h11, 32'h0);
        check("lb_sext", obs_ld, 32'hFFFFFFA5);
        do_op(1'b0, LBU, 32'h11, 32'h0);
        check("lbu_zext", obs_ld, 32'h000000A5);

        // halfword
        do_op(1'b0, SH, 32'h22, 32'h12348001);
        do_op(1'b0, LW, 32'h20, 32'h0);
        check("sh_low_half", obs_ld & 32'h0000FFFF, 32'h00008001);
        do_op(1'b0, LH, 32'h22, 32'h0);
        check("lh_sext", obs_ld, 32'hFFFF8001);
        do_op(1'b0, LHU, 32'h22, 32'h0);
        check("lhu_zext", obs_ld, 32'h00008001);

        // misalignment: SW at 0x13 must not write, fault sticks with first address
        do_op(1'b0, SW, 32'h13, 32'hCAFEF00D);
        check("mis_fault", 32'(Fault), 32'h1);
        check("mis_bad", BadAddr, 32'h13);
        do_op(1'b0, LW, 32'h10, 32'h0);
        check("mis_nowrite", obs_ld, 32'h00A50000);
        do_op(1'b0, LH, 32'h31, 32'h0);
        check("mis_lh_ld", obs_ld, 32'h0);
        check("mis_lh_wb", obs_wb, 32'h0);
        check("mis_bad_keep", BadAddr, 32'h13);

        // reset: store with RST is dropped, fault state clears
        do_op(1'b1, SW, 32'h40, 32'h55555555);
        check("rst2_fault", 32'(Fault), 32'h0);
        check("rst2_bad", BadAddr, 32'h0);
        // misaligned store right as reset deasserts still faults
        do_op(1'b0, SW, 32'h41, 32'h1);
        check("post_rst_fault", 32'(Fault), 32'h1);
        check("post_rst_bad", BadAddr, 32'h41);
        do_op(1'b0, LW, 32'h40, 32'h0);
        check("rst_nowrite", obs_ld, 32'h0);
        do_op(1'b0, 6'h00, 32'h7, 32'h0);
        check("add_wb", obs_wb, 32'h7);
        check("add_ld", obs_ld, 32'h0);

        // wrap-around
        do_op(1'b0, SW, 32'h1010, 32'h0BADF00D);
        do_op(1'b0, LW, 32'h0010, 32'h0);
        check("wrap", obs_ld, 32'h0BADF00D);

        // randomized traffic, occasional reset
        for (int k = 0; k < 3000; k++) begin
            raw  = $urandom;
            addr = ($urandom_range(0, 1) == 1) ? (raw & 32'hF000_007F) : (raw & 32'h0000_00FF);
            do_op(($urandom_range(0, 49) == 0), op_tbl[$urandom_range(0, 9)], addr, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Data-memory stage of the single-clock MIPS datapath, sitting directly downstream of the execute stage. It takes the ALU effective address (`Result`) and store data (`Rdata2`), performs word, halfword and byte loads and stores on a byte-enabled data memory, and produces the write-back value for the register file. Misaligned accesses are suppressed and recorded in a sticky fault register with the faulting address.

## Interface
- `DMEM_WORDS`, 1024: number of 32-bit words in data memory. Must be a power of two.
- `AW`, $clog2(DMEM_WORDS): word-index width.
- `CLK`  in  1: clock. All state updates on the rising edge.
- `RST`  in  1: synchronous reset, active-high.
- `Ins`  in  32: current instruction. `Ins[31:26]` is the opcode.
- `Result`  in  32: ALU result, used as the effective address for loads and stores.
- `Rdata2`  in  32: store data from the rt register.
- `WBdata`  out  32: write-back value. Extended load data for loads, otherwise `Result`.
- `Ldata`  out  32: extended load data. 0 when the instruction is not a load.
- `Fault`  out  1: sticky misalignment flag.
- `BadAddr`  out  32: `Result` of the first faulting access.

## Operation
- Opcodes handled:
  - loads: LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25
  - stores: SB 0x28, SH 0x29, SW 0x2B
  - any other opcode neither reads nor writes memory.
- Word index is `Result[AW+1:2]`. Upper address bits are ignored, so addresses wrap modulo `4*DMEM_WORDS`.
- Byte order is big-endian. Byte offset 0 is bits [31:24] and offset 3 is bits [7:0]. Halfword offset 0 is bits [31:16].
- Loads:
  - LW returns the full word.
  - LB and LH sign-extend the selected byte or halfword.
  - LBU and LHU zero-extend it.
- Stores:
  - SB writes `Rdata2[7:0]` into the selected byte lane.
  - SH writes `Rdata2[15:0]` into the selected halfword.
  - SW writes the whole word.
  - Unselected lanes keep their contents.
- Misalignment is defined as:
  - LH, LHU or SH with `Result[0]`=1;
  - LW or SW with `Result[1:0]`≠0.
- On a misaligned access:
  - no memory write;
  - `Ldata` = 0, and `WBdata` = 0 for a load;
  - `Fault` is set on the next edge.
- `BadAddr` captures `Result` only if `Fault` was 0 before that edge. Later faults do not overwrite it.
- `Fault` and `BadAddr` clear only on `RST`.
- Memory contents are not cleared by reset. Simulation initialises memory to 0.

## Timing
- Reads are combinational (asynchronous). `Ldata` and `WBdata` are valid in the same cycle as `Ins` and `Result`.
- Writes commit on the rising edge at the end of the store cycle. A load in the following cycle sees the new data.
- During `RST`=1:
  - stores are suppressed;
  - `Fault` is driven to 0 and `BadAddr` to 0 at the edge.
  - `WBdata` and `Ldata` remain combinational.
- Reset values: `Fault`=0, `BadAddr`=0.
- A store issued in the same cycle that `RST` is asserted does not write.
- A misaligned store in the cycle `RST` deasserts behaves normally, meaning it faults.

## Structure
- Add the opcode constants LB, LH, LBU, LHU, SB and SH to `common_param.vh`, alongside the existing LW and SW.
- Sub-module `dmem_be`:
  - DMEM_WORDS×32 array;
  - 4-bit byte-enable synchronous write port;
  - asynchronous read port.
- `mem_stage` contains:
  - decode;
  - lane and byte-enable generation, plus store-data replication;
  - load extraction and extension;
  - fault logic.

## Test plan
- **Word round trip:** SW with `Result`=0x10 and `Rdata2`=0xDEADBEEF, then LW at 0x10 → `Ldata`=0xDEADBEEF and `WBdata`=0xDEADBEEF.
- **Byte lanes:**
  - SB at 0x11 with `Rdata2`=0x000000A5 over a word of 0 → word at 0x10 = 0x00A50000;
  - LB at 0x11 → 0xFFFFFFA5;
  - LBU at 0x11 → 0x000000A5.
- **Halfword:**
  - SH at 0x22 with `Rdata2`=0x12348001 → word at 0x20 has bits [15:0] = 0x8001;
  - LH at 0x22 → 0xFFFF8001;
  - LHU at 0x22 → 0x00008001.
- **Misalignment:**
  - SW at 0x13 → memory unchanged, `Fault`=1 after the edge, `BadAddr`=0x13;
  - a subsequent LH at 0x31 → `Ldata`=0 and `BadAddr` stays 0x13.
- **Reset:**
  - an SW asserted together with `RST` leaves memory unchanged;
  - `Fault` and `BadAddr` read 0 after the reset edge;
  - an ADD with `Result`=7 → `WBdata`=7.
- **Wrap-around:** with `DMEM_WORDS`=1024, SW at 0x1010 followed by LW at 0x0010 → same data.
